// File: rtl/rotating_queue_fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared types and helpers for the rotating queue FIFO.
//   - rot_dir_e   : rotation direction (left = head items go to tail)
//   - rot_state_e : rotation controller states
//   - is_pow2     : elaboration-time sanity check for DEPTH
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  typedef enum logic [1:0] {
    IDLE,
    ROT_STEP,
    DONE
  } rot_state_e;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : fifo_pkg

// File: rtl/rotating_queue_fifo_ring_mem.sv
// ---------------------------------------------------------------------------
// fifo_ring_mem
//   DEPTH x DATA_WIDTH register array for the rotating queue FIFO.
//   One synchronous write port, two asynchronous read ports (queue head and
//   the source entry of a rotation step).
//
//   clk        : clock
//   wr_en      : write enable
//   wr_addr    : write address
//   wr_data    : write data
//   rd_addr_a  : read port A address (head)
//   rd_data_a  : read port A data
//   rd_addr_b  : read port B address (step source)
//   rd_data_b  : read port B data
// ---------------------------------------------------------------------------
module fifo_ring_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy lives in the pointer/count logic,
  // so stale entries are never observable and a reset here would only cost
  // a reset net to every bit of the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule : fifo_ring_mem

// File: rtl/rotating_queue_fifo.sv
// ---------------------------------------------------------------------------
// rotating_queue_fifo
//   Ring-buffer FIFO with valid/ready write and read ports plus a rotate
//   command that cyclically shifts the occupied entries in queue order.
//   A full queue rotates by moving the head pointer; a partially filled one
//   moves one entry per cycle from one end of the queue to the other.
//
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_data : producer push handshake
//   rd_valid/rd_ready/rd_data : consumer pop handshake (rd_data = 0 if !rd_valid)
//   rot_valid/rot_ready       : rotate command handshake
//   rot_amount, rot_dir       : rotate steps and direction (0 left, 1 right)
//   rot_done    : one-cycle pulse when a rotation completes
//   busy        : rotation in progress
//   data_count  : number of occupied entries
// ---------------------------------------------------------------------------
module rotating_queue_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  input  logic                  rot_valid,
  input  logic [ADDR_WIDTH-1:0] rot_amount,
  input  logic                  rot_dir,
  output logic                  rot_ready,
  output logic                  rot_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   data_count
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("rotating_queue_fifo: DEPTH must be a power of two and at least 2");
  end

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_TWO   = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rot_state_e            state;
  rot_dir_e              dir_q;
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] steps_left;
  logic [ADDR_WIDTH:0]   count;

  // -------------------------------------------------------------------------
  // Derived status
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] tail;
  logic                  full;
  logic                  empty;
  logic                  idle;
  logic                  push;
  logic                  pop;
  logic                  rot_accept;
  logic                  rot_trivial;
  logic                  step_en;

  // count == DEPTH wraps to tail == head, which is the correct slot for
  // pointer-only rotation and is never written by a push (full refuses).
  assign tail  = head + count[ADDR_WIDTH-1:0];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign idle  = (state == IDLE);

  // Rotation has priority: a pending rot_valid blocks both data ports.
  assign wr_ready  = idle && !full  && !rot_valid;
  assign rd_valid  = idle && !empty && !rot_valid;
  assign rot_ready = idle;
  assign rot_done  = (state == DONE);
  assign busy      = !idle;
  assign data_count = count;

  assign push        = wr_valid && wr_ready;
  assign pop         = rd_valid && rd_ready;
  assign rot_accept  = rot_valid && idle;
  assign rot_trivial = (rot_amount == '0) || (count < CNT_TWO);
  assign step_en     = (state == ROT_STEP);

  // -------------------------------------------------------------------------
  // Storage. During a step the write port is borrowed by the rotation: a
  // left step copies head -> tail, a right step copies tail-1 -> head-1.
  // Pushes cannot collide because wr_ready is low outside IDLE.
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [ADDR_WIDTH-1:0] step_src_addr;
  logic [DATA_WIDTH-1:0] step_src_data;
  logic [DATA_WIDTH-1:0] head_data;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_wr_addr   = tail;
    mem_wr_data   = wr_data;
    step_src_addr = head;
    if (step_en) begin
      if (dir_q == ROT_LEFT) begin
        step_src_addr = head;
        mem_wr_addr   = tail;
      end else begin
        step_src_addr = tail - PTR_ONE;
        mem_wr_addr   = head - PTR_ONE;
      end
      mem_wr_data = step_src_data;
    end
  end

  fifo_ring_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en     (push || step_en),
    .wr_addr   (mem_wr_addr),
    .wr_data   (mem_wr_data),
    .rd_addr_a (head),
    .rd_data_a (head_data),
    .rd_addr_b (step_src_addr),
    .rd_data_b (step_src_data)
  );

  // Popped slots keep their old contents; masking here hides them.
  assign rd_data = rd_valid ? head_data : '0;

  // -------------------------------------------------------------------------
  // Pointers, occupancy and rotation controller
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_q      <= ROT_LEFT;
      head       <= '0;
      count      <= '0;
      steps_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rot_accept) begin
            if (rot_trivial) begin
              state <= DONE;
            end else if (full) begin
              // Every slot is occupied, so rotating is just re-basing head.
              head  <= (rot_dir == ROT_RIGHT) ? head - rot_amount
                                              : head + rot_amount;
              state <= DONE;
            end else begin
              steps_left <= rot_amount;
              dir_q      <= rot_dir_e'(rot_dir);
              state      <= ROT_STEP;
            end
          end else begin
            if (pop) begin
              head <= head + PTR_ONE;
            end
            case ({push, pop})
              2'b10:   count <= count + CNT_ONE;
              2'b01:   count <= count - CNT_ONE;
              default: count <= count;
            endcase
          end
        end

        ROT_STEP: begin
          // Amounts >= count simply keep cycling; the net effect is
          // amount mod count without needing a divider.
          head       <= (dir_q == ROT_LEFT) ? head + PTR_ONE : head - PTR_ONE;
          steps_left <= steps_left - PTR_ONE;
          if (steps_left == PTR_ONE) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : rotating_queue_fifo
